// File: rtl/seq_mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier: default width,
// FSM state encoding and the bit-counter width helper.
package seq_mult_pkg;

    localparam int LENGTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_COMPUTE = 2'b01,
        ST_DONE    = 2'b10
    } state_e;

    // Wide enough to hold the value LENGTH itself, not just LENGTH-1.
    function automatic int count_width(input int len);
        return $clog2(len) + 1;
    endfunction

endpackage

// File: rtl/seq_mult_datapath.sv
// Datapath of the sequential multiplier: operand magnitude/sign capture,
// shifted-multiplicand register, product accumulator and bit counter.
module seq_mult_datapath
    import seq_mult_pkg::*;
#(
    parameter int LENGTH = LENGTH_DEFAULT,
    parameter int CW     = count_width(LENGTH)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  step,
    input  logic [LENGTH-1:0]     multiplier,
    input  logic [LENGTH-1:0]     multiplicand,
    output logic [2*LENGTH-1:0]   acc,
    output logic [2*LENGTH-1:0]   acc_next,
    output logic                  sign,
    output logic [CW-1:0]         count
);

    logic [LENGTH-1:0]   a_mag_q, a_mag_d;
    logic [2*LENGTH-1:0] b_shift_q, b_shift_d;
    logic [2*LENGTH-1:0] acc_q, acc_d;
    logic                sign_q, sign_d;
    logic [CW-1:0]       count_q, count_d;
    logic [LENGTH-1:0]   a_mag_s, b_mag_s;
    logic [2*LENGTH-1:0] addend_s;

    // Next-state logic: capture magnitudes on load, one shift-add step per cycle otherwise.
    always_comb begin
        // Negating the most negative value wraps to itself, which read unsigned is 2^(LENGTH-1).
        a_mag_s   = multiplier[LENGTH-1]   ? (-multiplier)   : multiplier;
        b_mag_s   = multiplicand[LENGTH-1] ? (-multiplicand) : multiplicand;
        addend_s  = a_mag_q[0] ? b_shift_q : {(2*LENGTH){1'b0}};
        a_mag_d   = a_mag_q;
        b_shift_d = b_shift_q;
        acc_d     = acc_q;
        sign_d    = sign_q;
        count_d   = count_q;
        if (load) begin
            a_mag_d   = a_mag_s;
            b_shift_d = {{LENGTH{1'b0}}, b_mag_s};
            acc_d     = {(2*LENGTH){1'b0}};
            sign_d    = multiplier[LENGTH-1] ^ multiplicand[LENGTH-1];
            count_d   = {CW{1'b0}};
        end else if (step) begin
            a_mag_d   = {1'b0, a_mag_q[LENGTH-1:1]};
            b_shift_d = {b_shift_q[2*LENGTH-2:0], 1'b0};
            acc_d     = acc_q + addend_s;
            count_d   = count_q + CW'(1);
        end else begin
            a_mag_d   = a_mag_q;
            b_shift_d = b_shift_q;
            acc_d     = acc_q;
            sign_d    = sign_q;
            count_d   = count_q;
        end
    end

    // Datapath state registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            a_mag_q   <= {LENGTH{1'b0}};
            b_shift_q <= {(2*LENGTH){1'b0}};
            acc_q     <= {(2*LENGTH){1'b0}};
            sign_q    <= 1'b0;
            count_q   <= {CW{1'b0}};
        end else begin
            a_mag_q   <= a_mag_d;
            b_shift_q <= b_shift_d;
            acc_q     <= acc_d;
            sign_q    <= sign_d;
            count_q   <= count_d;
        end
    end

    assign acc      = acc_q;
    assign acc_next = acc_d;
    assign sign     = sign_q;
    assign count    = count_q;

endmodule

// File: rtl/sequential_multiplier.sv
// Signed sequential multiplier: returns |A*B| plus a sign flag after LENGTH
// shift-add cycles. Holds the control FSM and the registered status flags.
module sequential_multiplier
    import seq_mult_pkg::*;
#(
    parameter int LENGTH = LENGTH_DEFAULT
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [LENGTH-1:0]   multiplier,
    input  logic [LENGTH-1:0]   multiplicand,
    output logic [2*LENGTH-1:0] product,
    output logic                Computing,
    output logic                Ready,
    output logic                Negative
);

    localparam int CW = count_width(LENGTH);

    if (LENGTH < 2) begin : g_length_check
        $error("sequential_multiplier: LENGTH must be at least 2");
    end

    state_e              state_q, state_d;
    logic                computing_q, computing_d;
    logic                ready_q, ready_d;
    logic                negative_q, negative_d;
    logic                load_s, step_s, sign_s;
    logic [2*LENGTH-1:0] acc_s, acc_next_s;
    logic [CW-1:0]       count_s;

    seq_mult_datapath #(
        .LENGTH (LENGTH),
        .CW     (CW)
    ) u_datapath (
        .clock        (clock),
        .reset        (reset),
        .load         (load_s),
        .step         (step_s),
        .multiplier   (multiplier),
        .multiplicand (multiplicand),
        .acc          (acc_s),
        .acc_next     (acc_next_s),
        .sign         (sign_s),
        .count        (count_s)
    );

    // Next-state and flag logic; flags are updated together with the state transition.
    always_comb begin
        state_d     = state_q;
        computing_d = computing_q;
        ready_d     = ready_q;
        negative_d  = negative_q;
        load_s      = 1'b0;
        step_s      = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d     = ST_COMPUTE;
                    load_s      = 1'b1;
                    computing_d = 1'b1;
                    ready_d     = 1'b0;
                    negative_d  = 1'b0;
                end else begin
                    state_d     = state_q;
                end
            end
            ST_COMPUTE: begin
                step_s = 1'b1;
                if (count_s == CW'(LENGTH - 1)) begin
                    state_d     = ST_DONE;
                    computing_d = 1'b0;
                    ready_d     = 1'b1;
                    // A zero product is never reported as negative.
                    negative_d  = sign_s & (acc_next_s != {(2*LENGTH){1'b0}});
                end else begin
                    state_d     = ST_COMPUTE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                computing_d = 1'b0;
                ready_d     = 1'b0;
                negative_d  = 1'b0;
            end
        endcase
    end

    // FSM state and status-flag registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            computing_q <= 1'b0;
            ready_q     <= 1'b0;
            negative_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            computing_q <= computing_d;
            ready_q     <= ready_d;
            negative_q  <= negative_d;
        end
    end

    assign product   = acc_s;
    assign Computing = computing_q;
    assign Ready     = ready_q;
    assign Negative  = negative_q;

endmodule

// File: tb/tb_sequential_multiplier.sv
// Scoreboard bench for sequential_multiplier (LENGTH=8): expected results are
// queued when operands are driven and compared when Ready is reported.
module tb_sequential_multiplier;

    localparam int L = 8;

    typedef struct packed {
        logic [2*L-1:0] prod;
        logic           neg;
    } exp_t;

    logic           clock;
    logic           reset;
    logic           start;
    logic [L-1:0]   multiplier;
    logic [L-1:0]   multiplicand;
    logic [2*L-1:0] product;
    logic           Computing;
    logic           Ready;
    logic           Negative;

    exp_t sb_q[$];
    int   n_compared;
    int   n_mismatched;

    sequential_multiplier #(.LENGTH(L)) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .multiplier   (multiplier),
        .multiplicand (multiplicand),
        .product      (product),
        .Computing    (Computing),
        .Ready        (Ready),
        .Negative     (Negative)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [L-1:0] a, input logic [L-1:0] b);
        exp_t e;
        int sa, sb, ma, mb, p;
        sa = int'($signed(a));
        sb = int'($signed(b));
        ma = (sa < 0) ? -sa : sa;
        mb = (sb < 0) ? -sb : sb;
        p  = ma * mb;
        e.prod = p[2*L-1:0];
        e.neg  = ((sa < 0) != (sb < 0)) && (p != 0);
        return e;
    endfunction

    task automatic check_result(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_nonempty"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            chk({tag, "_product"}, product, e.prod);
            chk({tag, "_negative"}, Negative, e.neg);
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_product"}, product, 0);
        chk({tag, "_computing"}, Computing, 0);
        chk({tag, "_ready"}, Ready, 0);
        chk({tag, "_negative"}, Negative, 0);
    endtask

    // One full multiplication; optionally disturbs operands/start mid-compute.
    task automatic run_mult(input logic [L-1:0] a, input logic [L-1:0] b,
                            input bit disturb, input string tag);
        @(posedge clock); #1;
        multiplier   = a;
        multiplicand = b;
        start        = 1'b1;
        sb_q.push_back(model(a, b));
        @(posedge clock); #1;
        start = 1'b0;
        for (int i = 0; i < L; i++) begin
            @(negedge clock);
            chk({tag, "_computing"}, Computing, 1);
            chk({tag, "_ready_low"}, Ready, 0);
            if (disturb && i == 2) begin
                multiplier   = 8'h03;
                multiplicand = 8'h05;
                start        = 1'b1;
            end
            if (disturb && i == 3) begin
                start = 1'b0;
            end
        end
        @(negedge clock);
        chk({tag, "_ready"}, Ready, 1);
        chk({tag, "_computing_low"}, Computing, 0);
        check_result(tag);
    endtask

    logic [L-1:0] b2b_a [3];
    logic [L-1:0] b2b_b [3];

    initial begin
        int k;
        bit rdy_exp;
        n_compared   = 0;
        n_mismatched = 0;
        reset        = 1'b1;
        start        = 1'b0;
        multiplier   = 8'd8;
        multiplicand = 8'd3;

        // Reset held with clock running; start toggled mid-way must change nothing.
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            start = (i == 1 || i == 2);
            check_idle($sformatf("rst_hold%0d", i));
        end
        start = 1'b0;
        reset = 1'b0;
        @(negedge clock);
        check_idle("post_rst");

        run_mult(8'd8, 8'd3, 1'b0, "m8x3");
        repeat (3) @(negedge clock);
        chk("hold_ready", Ready, 1);
        chk("hold_product", product, 24);

        run_mult(8'hFB, 8'd7,  1'b0, "mneg5x7");
        run_mult(8'hFB, 8'hF9, 1'b0, "mneg5xneg7");
        run_mult(8'h80, 8'h80, 1'b0, "mmin");
        run_mult(8'd0,  8'hFD, 1'b0, "mzero");

        // Abort four cycles into compute; outputs must clear without a clock edge.
        @(posedge clock); #1;
        multiplier   = 8'd100;
        multiplicand = 8'd100;
        start        = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (4) @(negedge clock);
        chk("abort_busy", Computing, 1);
        reset = 1'b1;
        #1;
        check_idle("abort_now");
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check_idle("abort_after");
        run_mult(8'd2, 8'd3, 1'b0, "m2x3");

        run_mult(8'd12, 8'hF5, 1'b1, "disturb");

        // Start held high: a result every L+1 cycles, Ready high one cycle each.
        b2b_a[0] = 8'd7;    b2b_b[0] = 8'd9;
        b2b_a[1] = 8'hEC;   b2b_b[1] = 8'd6;
        b2b_a[2] = 8'h7F;   b2b_b[2] = 8'h81;
        @(posedge clock); #1;
        multiplier   = b2b_a[0];
        multiplicand = b2b_b[0];
        start        = 1'b1;
        sb_q.push_back(model(b2b_a[0], b2b_b[0]));
        @(posedge clock);
        k = 1;
        for (int j = 0; j < 3 * (L + 1); j++) begin
            @(negedge clock);
            rdy_exp = (j >= L) && (((j - L) % (L + 1)) == 0);
            chk($sformatf("b2b_ready%0d", j), Ready, rdy_exp);
            chk($sformatf("b2b_computing%0d", j), Computing, !rdy_exp);
            if (rdy_exp) begin
                check_result($sformatf("b2b%0d", j));
                if (k < 3) begin
                    multiplier   = b2b_a[k];
                    multiplicand = b2b_b[k];
                    sb_q.push_back(model(b2b_a[k], b2b_b[k]));
                    k++;
                end
            end
        end
        start = 1'b0;
        @(negedge clock);
        chk("b2b_final_hold", Ready, 1);
        chk("sb_drained", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
